// File: rtl/cpu_pkg.sv
// Shared types and constants for the LEGv8 fetch / PC logic.
// Optional build macro used by the fetch block: FETCH_PERF_CNT_EN.
package cpu_pkg;

   // Fetch sequencer states: dead cycle, memory request, execute.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      EXEC = 2'd2
   } fetch_state_t;

   // Branch-select encodings driven by the decoder on brTaken.
   localparam logic [1:0] BR_SEQ = 2'b00;
   localparam logic [1:0] BR_REL = 2'b01;
   localparam logic [1:0] BR_REG = 2'b10;

   // Every LEGv8 instruction occupies one 32-bit word.
   localparam int INSTR_BYTES = 4;

   // True for the two encodings that redirect the PC.
   function automatic logic is_taken(input logic [1:0] br);
      return (br == BR_REL) || (br == BR_REG);
   endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Next-PC arithmetic for the fetch unit: sequential pc+4, PC-relative
// B/BL (imm26) and conditional (imm19) targets, and BR register target.
// Purely combinational; all sums wrap modulo 2^ADDR_W.
module branch_target_calc
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 64
) (
   input  logic [ADDR_W-1:0] i_pc,
   input  logic [25:0]       i_imm_field,
   input  logic [1:0]        i_br_taken,
   input  logic              i_uncond_br,
   input  logic [ADDR_W-1:0] i_reg_target,
   output logic [ADDR_W-1:0] o_seq_pc,
   output logic [ADDR_W-1:0] o_next_pc
);

   logic signed [ADDR_W-1:0] w_off26;
   logic signed [ADDR_W-1:0] w_off19;
   logic        [ADDR_W-1:0] w_rel_target;

   // Word offsets are sign-extended and scaled to bytes in one step.
   function automatic logic signed [ADDR_W-1:0] sext_imm26(input logic [25:0] imm);
      return $signed({{(ADDR_W-28){imm[25]}}, imm, 2'b00});
   endfunction

   function automatic logic signed [ADDR_W-1:0] sext_imm19(input logic [18:0] imm);
      return $signed({{(ADDR_W-21){imm[18]}}, imm, 2'b00});
   endfunction

   assign w_off26      = sext_imm26(i_imm_field);
   assign w_off19      = sext_imm19(i_imm_field[23:5]);
   assign o_seq_pc     = i_pc + ADDR_W'(INSTR_BYTES);
   assign w_rel_target = i_pc + $unsigned(i_uncond_br ? w_off26 : w_off19);

   // Select the next PC; 11 and unknown encodings fall through to sequential.
   always_comb begin
      o_next_pc = o_seq_pc;
      case (i_br_taken)
         BR_SEQ:  o_next_pc = o_seq_pc;
         BR_REL:  o_next_pc = w_rel_target;
         BR_REG:  o_next_pc = i_reg_target;
         default: o_next_pc = o_seq_pc;
      endcase
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// LEGv8 fetch / program-counter unit.
// Sequences IDLE -> REQ -> EXEC, fetching one instruction over a ready
// handshake, presenting it to the decoder for one execute cycle and
// updating the PC at the end of that cycle.
// Build macro FETCH_PERF_CNT_EN adds retired / taken-branch counters.
module fetch_pc_unit
   import cpu_pkg::*;
#(
   parameter int              ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imemReq,
   output logic [ADDR_W-1:0] imemAddr,
   input  logic              imemReady,
   input  logic [31:0]       imemData,
   output logic [31:0]       instruction,
   output logic              instrValid,
   input  logic [1:0]        brTaken,
   input  logic              unCondBr,
   input  logic [ADDR_W-1:0] regTarget,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] linkAddr
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       retiredCnt,
   output logic [31:0]       takenCnt
`endif
);

   fetch_state_t      r_state;
   fetch_state_t      w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [ADDR_W-1:0] w_seq_pc;
   logic [31:0]       r_instr;
   logic              w_in_req;
   logic              w_in_exec;

   assign w_in_req  = (r_state == REQ);
   assign w_in_exec = (r_state == EXEC);

   // Next-state logic: one dead cycle after reset, then REQ/EXEC alternation.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = REQ;
         REQ:     w_state_nxt = imemReady ? EXEC : REQ;
         EXEC:    w_state_nxt = REQ;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register; reset abandons any outstanding fetch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Program counter advances only at the end of the execute cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          r_pc <= RESET_PC;
      else if (w_in_exec) r_pc <= w_pc_nxt;
   end

   // Instruction latch captures memory data on the accepted request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                     r_instr <= 32'h0;
      else if (w_in_req && imemReady) r_instr <= imemData;
   end

   branch_target_calc #(
      .ADDR_W(ADDR_W)
   ) u_branch_target_calc (
      .i_pc        (r_pc),
      .i_imm_field (r_instr[25:0]),
      .i_br_taken  (brTaken),
      .i_uncond_br (unCondBr),
      .i_reg_target(regTarget),
      .o_seq_pc    (w_seq_pc),
      .o_next_pc   (w_pc_nxt)
   );

   assign imemReq     = w_in_req;
   assign imemAddr    = r_pc;
   assign instrValid  = w_in_exec;
   assign instruction = r_instr;
   assign pc          = r_pc;
   assign linkAddr    = w_seq_pc;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_retired_cnt;
   logic [31:0] r_taken_cnt;

   // Count every executed instruction and every redirecting branch; both wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_retired_cnt <= 32'h0;
         r_taken_cnt   <= 32'h0;
      end else if (w_in_exec) begin
         r_retired_cnt <= r_retired_cnt + 32'd1;
         if (is_taken(brTaken)) r_taken_cnt <= r_taken_cnt + 32'd1;
      end
   end

   assign retiredCnt = r_retired_cnt;
   assign takenCnt   = r_taken_cnt;
`endif

endmodule
